// File: rtl/sm_reg_snapshot.sv
`default_nettype none
// ============================================================================
//  Module   : sm_reg_snapshot
//  Purpose  : Debug register-snapshot engine for the sm_top debug read port.
//             A start pulse freezes the CPU (cpu_hold), sweeps reg_addr over
//             REG_FIRST..REG_LAST capturing reg_data into a buffer, then
//             releases the CPU and streams {address, data} pairs out over a
//             valid/ready interface.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             start           - snapshot request (honoured only when idle)
//             reg_addr        - register index to sm_top regAddr
//             reg_data        - combinational read data from sm_top regData
//             cpu_hold        - high while scanning (inverted into clkEnable)
//             busy            - high while scanning or draining
//             out_valid/ready - stream handshake
//             out_addr/data   - current stream word (buffer read)
//             done            - one-cycle pulse after the last word transfers
//             snap_cnt        - completed-snapshot counter, wraps
//  Revision : 1.0 - initial release
// ============================================================================
module sm_reg_snapshot #(
    parameter int REG_FIRST = 0,
    parameter int REG_LAST  = 31,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [4:0]       reg_addr,
    input  logic [31:0]      reg_data,
    output logic             cpu_hold,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_addr,
    output logic [31:0]      out_data,
    output logic             done,
    output logic [CNT_W-1:0] snap_cnt
);

    localparam int         DEPTH   = REG_LAST - REG_FIRST + 1;
    // Buffer index width; a single-entry buffer still needs a 1-bit index.
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] c_FIRST = 5'(REG_FIRST);
    localparam logic [4:0] c_LAST  = 5'(REG_LAST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [4:0]       r_reg_addr, w_reg_addr_nxt;
    logic [4:0]       r_rd_idx, w_rd_idx_nxt;
    logic             r_cpu_hold, w_cpu_hold_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_done, w_done_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_off;
    logic [AW-1:0]    w_rd_off;

    logic [31:0]      r_buf [0:(2**AW)-1];

    // During SCAN reg_addr doubles as the write index; the buffer is stored
    // relative to REG_FIRST so only the captured range is allocated.
    assign w_wr_off = AW'(r_reg_addr - c_FIRST);
    assign w_rd_off = AW'(r_rd_idx - c_FIRST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_reg_addr <= 5'd0;
            r_rd_idx   <= 5'd0;
            r_cpu_hold <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_reg_addr <= w_reg_addr_nxt;
            r_rd_idx   <= w_rd_idx_nxt;
            r_cpu_hold <= w_cpu_hold_nxt;
            r_busy     <= w_busy_nxt;
            r_valid    <= w_valid_nxt;
            r_done     <= w_done_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[w_wr_off] <= reg_data;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_reg_addr_nxt = r_reg_addr;
        w_rd_idx_nxt   = r_rd_idx;
        w_cpu_hold_nxt = r_cpu_hold;
        w_busy_nxt     = r_busy;
        w_valid_nxt    = r_valid;
        w_done_nxt     = 1'b0;
        w_cnt_nxt      = r_cnt;
        w_wr_en        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt    = ST_SCAN;
                    w_reg_addr_nxt = c_FIRST;
                    w_cpu_hold_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                end
            end
            ST_SCAN: begin
                w_wr_en = 1'b1;
                if (r_reg_addr == c_LAST) begin
                    // reg_addr is left on REG_LAST rather than wrapping.
                    w_state_nxt    = ST_DRAIN;
                    w_cpu_hold_nxt = 1'b0;
                    w_rd_idx_nxt   = c_FIRST;
                    w_valid_nxt    = 1'b1;
                end else begin
                    w_reg_addr_nxt = r_reg_addr + 5'd1;
                end
            end
            ST_DRAIN: begin
                if (r_valid && out_ready) begin
                    if (r_rd_idx == c_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end else begin
                        w_rd_idx_nxt = r_rd_idx + 5'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign reg_addr  = r_reg_addr;
    assign cpu_hold  = r_cpu_hold;
    assign busy      = r_busy;
    assign out_valid = r_valid;
    assign out_addr  = r_rd_idx;
    assign out_data  = r_buf[w_rd_off];
    assign done      = r_done;
    assign snap_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sm_reg_snapshot.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sm_reg_snapshot
//  Purpose  : Self-checking bench for sm_reg_snapshot. Three instances:
//             k=0 full range (0..31, CNT_W=16), k=1 single entry (2..2),
//             k=2 full range with CNT_W=2. A reference model derives the
//             expected stream directly from the register-file array.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sm_reg_snapshot;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [2:0]       start, rdy, hold, busy, vld, done;
    logic [2:0][4:0]  ra, oa;
    logic [2:0][31:0] rd, od;
    logic [15:0]      cnt0, cnt1;
    logic [1:0]       cnt2;
    logic [31:0]      rf [0:31];

    // sm_top debug port model: combinational register-file read.
    assign rd[0] = rf[ra[0]];
    assign rd[1] = rf[ra[1]];
    assign rd[2] = rf[ra[2]];

    sm_reg_snapshot #(.REG_FIRST(0), .REG_LAST(31), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .reg_addr(ra[0]), .reg_data(rd[0]),
        .cpu_hold(hold[0]), .busy(busy[0]), .out_valid(vld[0]), .out_ready(rdy[0]),
        .out_addr(oa[0]), .out_data(od[0]), .done(done[0]), .snap_cnt(cnt0));

    sm_reg_snapshot #(.REG_FIRST(2), .REG_LAST(2), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .reg_addr(ra[1]), .reg_data(rd[1]),
        .cpu_hold(hold[1]), .busy(busy[1]), .out_valid(vld[1]), .out_ready(rdy[1]),
        .out_addr(oa[1]), .out_data(od[1]), .done(done[1]), .snap_cnt(cnt1));

    sm_reg_snapshot #(.REG_FIRST(0), .REG_LAST(31), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .reg_addr(ra[2]), .reg_data(rd[2]),
        .cpu_hold(hold[2]), .busy(busy[2]), .out_valid(vld[2]), .out_ready(rdy[2]),
        .out_addr(oa[2]), .out_data(od[2]), .done(done[2]), .snap_cnt(cnt2));

    int n_checks = 0;
    int n_fail   = 0;
    int hold_cyc [3];
    int vld_cyc  [3];
    int xfer     [3];
    int done_cnt [3];
    int ptr      [3];
    int scan_i   [3];
    int exp_snap [3];
    bit prev_done2 = 1'b0;

    function automatic int first_of(int k);
        return (k == 1) ? 2 : 0;
    endfunction

    function automatic int mod_of(int k);
        return (k == 2) ? 4 : 65536;
    endfunction

    function automatic logic [31:0] snap_of(int k);
        if (k == 0) return {16'd0, cnt0};
        if (k == 1) return {16'd0, cnt1};
        return {30'd0, cnt2};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_counts(input int k);
        hold_cyc[k] = 0; vld_cyc[k] = 0; xfer[k] = 0;
        done_cnt[k] = 0; ptr[k] = 0; scan_i[k] = 0;
    endtask

    // Reference model / monitor: the k-th instance must emit FIRST+i with
    // rf[FIRST+i] as its i-th word, present it until accepted, and never
    // be valid while holding the CPU.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (k == 2 && prev_done2 && start[2])
                    check("restart_gap_hold", {31'd0, hold[2]}, 32'd1);
                if (hold[k]) begin
                    check("scan_addr", {27'd0, ra[k]}, 32'(first_of(k) + scan_i[k]));
                    check("scan_valid_low", {31'd0, vld[k]}, 32'd0);
                    scan_i[k]++;
                    hold_cyc[k]++;
                end
                if (vld[k]) begin
                    vld_cyc[k]++;
                    check("drain_busy", {31'd0, busy[k]}, 32'd1);
                    check("word_addr", {27'd0, oa[k]}, 32'(first_of(k) + ptr[k]));
                    check("word_data", od[k], rf[(first_of(k) + ptr[k]) & 31]);
                    if (rdy[k]) begin
                        ptr[k]++;
                        xfer[k]++;
                    end
                end
                if (done[k]) begin
                    done_cnt[k]++;
                    exp_snap[k]++;
                    ptr[k]    = 0;
                    scan_i[k] = 0;
                    check("done_hold_low", {31'd0, hold[k]}, 32'd0);
                    check("snap_cnt", snap_of(k), 32'(exp_snap[k] % mod_of(k)));
                end
            end
            prev_done2 = done[2];
        end
    end

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        @(posedge clk);
        #1 start[k] = 1'b0;
    endtask

    // mode 0: ready=1, 1: ready pattern 1,0,0,1, 2: random ready,
    // 3: random ready plus one start pulse mid-drain.
    // Returns just after the edge following the done cycle.
    task automatic run_to_done(input int k, input int mode, input int budget);
        int  d0;
        int  c;
        bit  pulsed;
        d0 = done_cnt[k];
        c = 0;
        pulsed = 1'b0;
        while (done_cnt[k] == d0 && c < budget) begin
            @(posedge clk);
            c++;
            if (done_cnt[k] != d0) break;
            #1;
            case (mode)
                0:       rdy[k] = 1'b1;
                1:       rdy[k] = ((c % 4) == 0) || ((c % 4) == 3);
                default: rdy[k] = 1'($urandom_range(0, 1));
            endcase
            if (mode == 3) begin
                if (!pulsed && vld[k] && xfer[k] == 10) begin
                    start[k] = 1'b1;
                    pulsed = 1'b1;
                end else begin
                    start[k] = 1'b0;
                end
            end
        end
        check("done_seen", {31'd0, (done_cnt[k] != d0)}, 32'd1);
    endtask

    task automatic randomize_rf();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = '0; rdy = '0;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i * 32'h11);
        rf[0] = 32'h10;
        for (int k = 0; k < 3; k++) begin clear_counts(k); exp_snap[k] = 0; end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold",  {29'd0, hold},  32'd0);
        check("rst_busy",  {29'd0, busy},  32'd0);
        check("rst_valid", {29'd0, vld},   32'd0);
        check("rst_done",  {29'd0, done},  32'd0);
        check("rst_cnt0",  {16'd0, cnt0},  32'd0);
        check("rst_cnt2",  {30'd0, cnt2},  32'd0);
        check("rst_raddr", {27'd0, ra[0]}, 32'd0);
        check("rst_oaddr", {27'd0, oa[0]}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: full sweep, ready held high
        rdy[0] = 1'b1;
        pulse_start(0);
        run_to_done(0, 0, 200);
        check("t1_hold_cycles", 32'(hold_cyc[0]), 32'd32);
        check("t1_valid_cycles", 32'(vld_cyc[0]), 32'd32);
        check("t1_xfers", 32'(xfer[0]), 32'd32);
        check("t1_done_pulses", 32'(done_cnt[0]), 32'd1);
        check("t1_snap", {16'd0, cnt0}, 32'd1);
        repeat (3) @(posedge clk); #1;

        // 2: backpressure 1,0,0,1
        clear_counts(0);
        randomize_rf();
        rdy[0] = 1'b0;
        pulse_start(0);
        run_to_done(0, 1, 400);
        check("t2_hold_cycles", 32'(hold_cyc[0]), 32'd32);
        check("t2_xfers", 32'(xfer[0]), 32'd32);
        check("t2_done_pulses", 32'(done_cnt[0]), 32'd1);
        check("t2_snap", {16'd0, cnt0}, 32'd2);
        repeat (3) @(posedge clk); #1;

        // 3: start during SCAN (5th cycle) and mid-DRAIN is ignored
        clear_counts(0);
        randomize_rf();
        pulse_start(0);
        repeat (4) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        run_to_done(0, 3, 600);
        repeat (10) @(posedge clk); #1;
        check("t3_hold_cycles", 32'(hold_cyc[0]), 32'd32);
        check("t3_xfers", 32'(xfer[0]), 32'd32);
        check("t3_done_pulses", 32'(done_cnt[0]), 32'd1);
        check("t3_idle_busy", {31'd0, busy[0]}, 32'd0);
        check("t3_snap", {16'd0, cnt0}, 32'd3);

        // 4: reset in the 10th SCAN cycle
        clear_counts(0);
        pulse_start(0);
        repeat (9) @(posedge clk);
        #2;
        check("t4_pre_hold", {31'd0, hold[0]}, 32'd1);
        rst = 1'b1;
        #1;
        check("t4_async_hold",  {31'd0, hold[0]}, 32'd0);
        check("t4_async_busy",  {31'd0, busy[0]}, 32'd0);
        check("t4_async_valid", {31'd0, vld[0]},  32'd0);
        check("t4_async_snap",  {16'd0, cnt0},    32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_counts(0);
        exp_snap[0] = 0;
        randomize_rf();
        pulse_start(0);
        run_to_done(0, 2, 600);
        check("t4_hold_cycles", 32'(hold_cyc[0]), 32'd32);
        check("t4_xfers", 32'(xfer[0]), 32'd32);
        check("t4_snap", {16'd0, cnt0}, 32'd1);
        repeat (3) @(posedge clk); #1;

        // 5: single-entry instance
        rf[2] = 32'hDEADBEEF;
        rdy[1] = 1'b1;
        pulse_start(1);
        run_to_done(1, 0, 50);
        check("t5_hold_cycles", 32'(hold_cyc[1]), 32'd1);
        check("t5_xfers", 32'(xfer[1]), 32'd1);
        check("t5_done_pulses", 32'(done_cnt[1]), 32'd1);
        check("t5_snap", {16'd0, cnt1}, 32'd1);
        repeat (3) @(posedge clk); #1;

        // 6: CNT_W=2, five back-to-back snapshots, start held through done
        randomize_rf();
        rdy[2] = 1'b1;
        start[2] = 1'b1;
        for (int s = 0; s < 4; s++) run_to_done(2, 0, 200);
        #1 start[2] = 1'b0;
        run_to_done(2, 0, 200);
        repeat (5) @(posedge clk); #1;
        check("t6_done_pulses", 32'(done_cnt[2]), 32'd5);
        check("t6_hold_cycles", 32'(hold_cyc[2]), 32'd160);
        check("t6_xfers", 32'(xfer[2]), 32'd160);
        check("t6_snap_final", {30'd0, cnt2}, 32'd1);
        check("t6_idle_busy", {31'd0, busy[2]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
